imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder that serves the fetch side of the out-of-order core. It accepts PC requests over a valid/ready handshake and returns `{pc, instr, fault}` in request order after a fixed read latency. A credit counter bounds outstanding requests so the internal pipeline never stalls. A redirect flush discards every in-flight and queued response. A side write port preloads program contents for simulation and test.

## Interface
- `DEPTH`, default 256: memory size in 32-bit words; power of two.
- `LATENCY`, default 2: cycles from request accept to response-valid; must be ≥1.
- `QDEPTH`, default 4: maximum outstanding requests and response-FIFO depth; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a fetch request is present.
- `req_ready` out 1: the responder can accept a request.
- `req_pc` in 32: byte address of the requested instruction.
- `flush` in 1: redirect. Drops all outstanding work in the cycle it is asserted.
- `resp_valid` out 1: a response is at the head of the FIFO.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_pc` out 32: echoed request PC.
- `resp_instr` out 32: instruction word.
- `resp_fault` out 1: the request was misaligned or out of range.
- `prog_we` in 1: memory write enable.
- `prog_addr` in $clog2(DEPTH): word address for the write.
- `prog_data` in 32: write data.

## Operation
- Request accept: `req_valid && req_ready`. Response handshake: `resp_valid && resp_ready`.
- `req_ready = !reset && !flush && (count < QDEPTH)`. It has no combinational dependence on `resp_ready`.
- `count` (width $clog2(QDEPTH+1)) tracks accepted requests not yet handshaken:
  - +1 on accept;
  - −1 on response handshake;
  - unchanged when both occur in the same cycle;
  - 0 on flush or reset.
- Word index = `req_pc[31:2]`.
- Fault is set when `req_pc[1:0] != 0` or word index ≥ DEPTH.
  - On fault, `resp_instr = 32'h0000_0013` (NOP) and `resp_fault = 1`.
  - Otherwise the stored word is returned and `resp_fault = 0`.
- Memory read happens on accept. The read result enters pipeline stage 1.
- The pipeline has LATENCY stages of `{valid, pc, instr, fault}`.
  - It advances every cycle and never stalls.
  - The last stage pushes into the response FIFO.
  - The credit limit guarantees the FIFO always has room; overflow is impossible by construction, and verification asserts it.
- Response FIFO: QDEPTH entries, circular head/tail pointers.
  - Outputs are driven from the head entry.
  - When empty, `resp_valid = 0` and `resp_pc`/`resp_instr`/`resp_fault` are 0.
  - Responses leave in strict acceptance order.
- Flush takes priority over everything except reset. In the flush cycle:
  - all stage valids clear;
  - FIFO pointers reset (empty);
  - `count = 0`;
  - no request is accepted;
  - a response presented in that cycle is still observable, but its handshake has no further effect.
- `prog_we` writes `mem[prog_addr]` at the edge.
  - A same-cycle accept to the same word returns the old data (read-before-write).
  - Writes are legal at any time, including during flush.
- Memory contents are not cleared by reset.

## Timing
- Reset (synchronous): all stage valids are 0, FIFO is empty, `count = 0`, `resp_valid = 0`, response data is 0, `req_ready = 0` during reset. `req_ready = 1` in the first cycle after reset deasserts.
- Latency: request accepted at edge N appears with `resp_valid = 1` in the cycle after edge N+LATENCY, provided the FIFO was empty ahead of it.
- Throughput: 1 request/cycle sustained while `resp_ready = 1` requires QDEPTH ≥ LATENCY+2. With the defaults this holds and the stream is back-to-back.
- Backpressure: while `resp_ready = 0`, exactly QDEPTH requests are accepted, then `req_ready = 0`. Each response handshake re-enables `req_ready` in the following cycle.
- Flush: `resp_valid = 0` and `req_ready = 1` in the cycle after flush. The first post-flush accept responds after LATENCY cycles.
- Reset mid-stream has the same effect as flush and additionally holds `req_ready = 0` while `reset` is asserted.

## Test plan
- **Reset:** assert `reset` 2 cycles with `req_valid = 1` → no accepts, `resp_valid = 0`, outputs 0; `req_ready = 1` in the cycle after deassert.
- **Streaming:** preload words 0..3 with 0x11,0x22,0x33,0x44. Stream pc 0,4,8,12 with `resp_ready = 1` → responses 0x11..0x44 in consecutive cycles, first valid after edge N+2, `resp_fault = 0`.
- **Backpressure:** `resp_ready = 0`, offer 6 requests → 4 accepted, `req_ready = 0`. Raise `resp_ready` → 4 in-order responses, `req_ready` returns, remaining 2 served.
- **Flush:** flush with 3 requests outstanding → next cycle `resp_valid = 0`, `count = 0`. A request to pc 0x40 afterwards is the first response seen (`resp_pc = 0x40`).
- **Faults:** pc 0x2 → `resp_fault = 1`, `resp_instr = 0x13`. pc 0x400 with DEPTH = 256 → `resp_fault = 1`. pc 0x3FC → `resp_fault = 0`.
- **Read-before-write:** `prog_we` to word 5 with 0xAA in the same cycle as a pc 0x14 accept → response returns the old word. A second pc 0x14 request returns 0xAA.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed read latency,
// credit-limited so the read pipeline never stalls, with redirect flush and a preload port.
module imem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_pc,
    output logic [31:0]              resp_instr,
    output logic                     resp_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]        mem [DEPTH];

    logic [LATENCY-1:0] stg_valid_r;
    logic [31:0]        stg_pc_r    [LATENCY];
    logic [31:0]        stg_instr_r [LATENCY];
    logic [LATENCY-1:0] stg_fault_r;

    logic [31:0]        fifo_pc_r    [QDEPTH];
    logic [31:0]        fifo_instr_r [QDEPTH];
    logic [QDEPTH-1:0]  fifo_fault_r;
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [CW-1:0]      fifo_cnt_r;
    logic [CW-1:0]      count_r;

    logic               accept_s;
    logic               resp_hs_s;
    logic               push_s;
    logic               req_fault_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign req_ready   = !reset && !flush && (count_r < CW'(QDEPTH));
    assign accept_s    = req_valid && req_ready;
    assign resp_hs_s   = resp_valid && resp_ready;
    assign push_s      = stg_valid_r[LATENCY-1];
    assign req_fault_s = (req_pc[1:0] != 2'b00) || (req_pc[31:2] >= 30'(DEPTH));

    // Memory write, read-on-accept into stage 1 (old data wins), pipeline data shift, FIFO data write.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (accept_s) begin
            stg_pc_r[0]    <= req_pc;
            stg_instr_r[0] <= req_fault_s ? NOP_INSTR : mem[req_pc[AW+1:2]];
            stg_fault_r[0] <= req_fault_s;
        end
        for (int i = 1; i < LATENCY; i++) begin
            stg_pc_r[i]    <= stg_pc_r[i-1];
            stg_instr_r[i] <= stg_instr_r[i-1];
            stg_fault_r[i] <= stg_fault_r[i-1];
        end
        if (push_s) begin
            fifo_pc_r[tail_r]    <= stg_pc_r[LATENCY-1];
            fifo_instr_r[tail_r] <= stg_instr_r[LATENCY-1];
            fifo_fault_r[tail_r] <= stg_fault_r[LATENCY-1];
        end
    end

    // Control state: stage valids, FIFO pointers/occupancy and the outstanding-request credit count.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stg_valid_r <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            fifo_cnt_r  <= '0;
            count_r     <= '0;
        end else begin
            stg_valid_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid_r[i] <= stg_valid_r[i-1];
            end
            if (push_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (resp_hs_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push_s, resp_hs_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            case ({accept_s, resp_hs_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response outputs come from the FIFO head; all zero while empty.
    always_comb begin
        resp_valid = 1'b0;
        resp_pc    = 32'h0000_0000;
        resp_instr = 32'h0000_0000;
        resp_fault = 1'b0;
        if (fifo_cnt_r != '0) begin
            resp_valid = 1'b1;
            resp_pc    = fifo_pc_r[head_r];
            resp_instr = fifo_instr_r[head_r];
            resp_fault = fifo_fault_r[head_r];
        end else begin
            resp_valid = 1'b0;
            resp_pc    = 32'h0000_0000;
            resp_instr = 32'h0000_0000;
            resp_fault = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: an independent reference model and scoreboard check
// every cycle's req_ready, resp_valid timing and response contents.
module tb_imem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int QDEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_instr;
    logic        resp_fault;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pc    (resp_pc),
        .resp_instr (resp_instr),
        .resp_fault (resp_fault),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mmem [DEPTH];
    int          mcnt = 0;
    int          cyc = 0;
    int          n_asserts = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, evaluated mid-cycle while DUT outputs are stable.
    always @(negedge clk) begin
        logic exp_rdy;
        logic exp_v;
        logic flt;
        exp_t e;
        cyc++;
        exp_v   = 1'b0;
        exp_rdy = !reset && !flush && (mcnt < QDEPTH);
        check("req_ready", 72'(req_ready), 72'(exp_rdy));
        if (mon_en) begin
            exp_v = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
            check("resp_valid", 72'(resp_valid), 72'(exp_v));
            if (!exp_v) begin
                check("idle_out", {7'b0, resp_fault, resp_pc, resp_instr}, 72'd0);
            end else if (resp_ready) begin
                e = sb_q.pop_front();
                check("resp_data", {7'b0, resp_fault, resp_pc, resp_instr},
                      {7'b0, e.fault, e.pc, e.instr});
                mcnt--;
            end
        end
        if (req_valid && exp_rdy) begin
            flt     = (req_pc[1:0] != 2'b00) || (req_pc[31:2] >= 30'(DEPTH));
            e.pc    = req_pc;
            e.fault = flt;
            e.instr = flt ? 32'h0000_0013 : mmem[req_pc[9:2]];
            e.due   = cyc + LATENCY + 1;
            sb_q.push_back(e);
            mcnt++;
        end
        if (reset || flush) begin
            sb_q.delete();
            mcnt = 0;
        end
        if (prog_we) begin
            mmem[prog_addr] = prog_data;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [31:0] pc, input int bound);
        logic got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_pc    = pc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        req_valid = 1'b0;
        check("offer_accepted", 72'(got), 72'd1);
    endtask

    task automatic prog(input logic [7:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick(1);
        prog_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 32'h0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = 8'h0;
        prog_data  = 32'h0;

        // Reset held 2 cycles with a request offered: nothing accepted, outputs zero.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick(1);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 72'(req_ready), 72'd1);
        @(posedge clk);
        #1;

        // Preload program words.
        for (int i = 0; i <= 16; i++) begin
            if (i < 4) prog(8'(i), 32'h11 * (i + 1));
            else if (i == 5) prog(8'(i), 32'h55);
            else prog(8'(i), 32'h1000 + i);
        end
        prog(8'hFF, 32'hDEAD_BEEF);

        // Streaming, back-to-back with resp_ready high.
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) offer(32'(i * 4), 1);
        tick(6);

        // Backpressure: four accepts, then req_ready drops until a response leaves.
        resp_ready = 1'b0;
        for (int i = 4; i < 8; i++) offer(32'(i * 4), 1);
        req_valid = 1'b1;
        req_pc    = 32'h20;
        tick(3);
        @(negedge clk);
        check("bp_ready_low", 72'(req_ready), 72'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        offer(32'h20, 10);
        offer(32'h24, 10);
        tick(8);

        // Flush with three outstanding; the blocked request in the flush cycle must be dropped.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer(32'(i * 4), 1);
        tick(3);
        flush      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 32'h80;
        tick(1);
        flush = 1'b0;
        offer(32'h40, 1);
        tick(6);

        // Fault cases.
        offer(32'h2, 1);
        offer(32'h400, 1);
        offer(32'h3FC, 1);
        tick(6);

        // Read-before-write on word 5.
        prog_we   = 1'b1;
        prog_addr = 8'd5;
        prog_data = 32'hAA;
        offer(32'h14, 1);
        prog_we   = 1'b0;
        offer(32'h14, 1);
        tick(6);

        // Reset mid-stream discards in-flight work.
        resp_ready = 1'b0;
        offer(32'h0, 1);
        offer(32'h4, 1);
        reset = 1'b1;
        tick(1);
        reset      = 1'b0;
        resp_ready = 1'b1;
        tick(1);
        offer(32'h8, 1);
        tick(6);

        check("scoreboard_empty", 72'(sb_q.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
